// File: rtl/ssegment_scanner_if.sv
// Value/strobe inputs and multiplexed digit outputs of the seven-segment scanner.
interface ssegment_scanner_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic [3:0]          digit_val;
    logic                digit_en;
    logic [DIGITS-1:0]   anodes;
    logic                frame_start;

    modport master (
        output value, load, blank_lz,
        input  digit_val, digit_en, anodes, frame_start
    );

    modport slave (
        input  value, load, blank_lz,
        output digit_val, digit_en, anodes, frame_start
    );
endinterface

// File: rtl/ssegment_scanner.sv
// Time-multiplexed seven-segment digit scanner with tear-free (frame-aligned) value
// updates and optional leading-zero blanking. All outputs are registered.
module ssegment_scanner #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ssegment_scanner_if.slave bus
);
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t            state,         state_n;
    logic [CNT_W-1:0]  cnt,           cnt_n;
    logic [IDX_W-1:0]  idx,           idx_n;
    logic [VAL_W-1:0]  shadow,        shadow_n;
    logic [VAL_W-1:0]  disp,          disp_n;
    logic              pending,       pending_n;
    logic [3:0]        digit_val_q,   digit_val_n;
    logic              digit_en_q,    digit_en_n;
    logic [DIGITS-1:0] anodes_q,      anodes_n;
    logic              frame_start_q, frame_start_n;

    logic              boundary;
    logic              lz;
    logic [DIGITS-1:0] lead_zero;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shadow        <= '0;
            disp          <= '0;
            pending       <= 1'b0;
            digit_val_q   <= 4'h0;
            digit_en_q    <= 1'b0;
            anodes_q      <= AN_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shadow        <= shadow_n;
            disp          <= disp_n;
            pending       <= pending_n;
            digit_val_q   <= digit_val_n;
            digit_en_q    <= digit_en_n;
            anodes_q      <= anodes_n;
            frame_start_q <= frame_start_n;
        end
    end

    // Next-state: scan sequencing, frame-aligned display update, next outputs
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        idx_n         = idx;
        shadow_n      = shadow;
        disp_n        = disp;
        pending_n     = pending;
        boundary      = 1'b0;
        lz            = 1'b1;
        lead_zero     = '0;
        digit_val_n   = 4'h0;
        digit_en_n    = 1'b1;
        anodes_n      = AN_IDLE;
        frame_start_n = 1'b0;

        case (state)
            ST_IDLE: begin
                state_n  = ST_SCAN;
                cnt_n    = '0;
                idx_n    = '0;
                boundary = 1'b1;
            end
            ST_SCAN: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (bus.load) begin
            shadow_n  = bus.value;
            pending_n = 1'b1;
        end

        // A load on the boundary edge itself wins over the older shadow copy
        if (boundary) begin
            if (bus.load) begin
                disp_n    = bus.value;
                pending_n = 1'b0;
            end else if (pending) begin
                disp_n    = shadow;
                pending_n = 1'b0;
            end
        end

        // lead_zero[i]: nibbles i..DIGITS-1 of the next display value are all zero
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (disp_n[4*i +: 4] != 4'h0) begin
                lz = 1'b0;
            end
            lead_zero[i] = lz;
        end

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_n == IDX_W'(i)) begin
                digit_val_n = disp_n[4*i +: 4];
                anodes_n[i] = ~AN_ACTIVE_LOW;
                digit_en_n  = !(bus.blank_lz && (i != 0) && lead_zero[i]);
            end
        end

        frame_start_n = boundary;
    end

    assign bus.digit_val   = digit_val_q;
    assign bus.digit_en    = digit_en_q;
    assign bus.anodes      = anodes_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_ssegment_scanner.sv
// Bench for ssegment_scanner: directed scenarios plus random loads, each cycle checked
// against a time-index based reference model of the scan and frame-aligned update rules.
module tb_ssegment_scanner;
    localparam int DIG   = 4;
    localparam int RD    = 4;
    localparam int FRAME = DIG * RD;
    localparam logic [9:0] IDLE_OUT = {4'b1111, 4'h0, 1'b0, 1'b0};

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // Reference model: m_t counts edges since scanning began
    bit          m_started;
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    bit          m_pending;
    bit          m_fs;
    bit          m_blank;

    logic [9:0]  obs;
    logic [9:0]  exp_v;

    ssegment_scanner_if #(.DIGITS(DIG)) bus ();

    ssegment_scanner #(
        .DIGITS       (DIG),
        .REFRESH_DIV  (RD),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_started = 1'b0;
        m_t       = 0;
        m_shadow  = 16'h0;
        m_disp    = 16'h0;
        m_pending = 1'b0;
        m_fs      = 1'b0;
        m_blank   = 1'b0;
    endtask

    function automatic logic [9:0] model_out();
        int          d;
        logic [15:0] up;
        logic [3:0]  an;
        logic        en;
        if (!m_started) return IDLE_OUT;
        d  = (m_t / RD) % DIG;
        up = m_disp >> (4 * d);
        an = ~(4'b0001 << d);
        en = !(m_blank && (d > 0) && (up == 16'h0));
        return {an, up[3:0], en, m_fs};
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then sample
    task automatic tick();
        logic        ld;
        logic        b;
        logic [15:0] v;
        logic [15:0] osh;
        bit          op;
        bit          bnd;
        ld  = bus.load;
        v   = bus.value;
        b   = bus.blank_lz;
        bnd = 1'b0;
        @(posedge clk);
        if (rst_n) begin
            osh = m_shadow;
            op  = m_pending;
            if (!m_started) begin
                m_started = 1'b1;
                m_t       = 0;
                bnd       = 1'b1;
            end else begin
                m_t++;
                bnd = ((m_t % FRAME) == 0);
            end
            if (ld) begin
                m_shadow  = v;
                m_pending = 1'b1;
            end
            if (bnd) begin
                if (ld) begin
                    m_disp    = v;
                    m_pending = 1'b0;
                end else if (op) begin
                    m_disp    = osh;
                    m_pending = 1'b0;
                end
            end
            m_fs    = bnd;
            m_blank = b;
        end
        #1;
        obs   = {bus.anodes, bus.digit_val, bus.digit_en, bus.frame_start};
        exp_v = model_out();
    endtask

    task automatic test_reset();
        bus.load     = 1'b0;
        bus.value    = 16'h0;
        bus.blank_lz = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        model_reset();
        #1;
        obs = {bus.anodes, bus.digit_val, bus.digit_en, bus.frame_start};
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", obs, IDLE_OUT);
        end
        repeat (2) begin
            tick();
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("FAIL reset_hold got=%b want=%b", obs, IDLE_OUT);
            end
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.anodes !== 4'b1110 || bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_edge got anodes=%b fs=%b want anodes=1110 fs=1",
                     bus.anodes, bus.frame_start);
        end
        repeat (2 * FRAME + 2) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL scan t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_load_midframe();
        for (int k = 0; k < FRAME && (m_t % FRAME) != 5; k++) tick();
        bus.value = 16'h12AB;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        checks++;
        if (bus.digit_val !== 4'h0) begin
            errors++;
            $display("FAIL load_midframe_tear got=%h want=0", bus.digit_val);
        end
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_midframe t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_blank();
        bus.blank_lz = 1'b1;
        bus.value    = 16'h0050;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blank_0050 t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
        bus.value = 16'h0000;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blank_0000 t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
        bus.blank_lz = 1'b0;
        repeat (FRAME) begin
            tick();
            checks++;
            if (bus.digit_en !== 1'b1 || obs !== exp_v) begin
                errors++;
                $display("FAIL blank_off t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_wrap_load();
        for (int k = 0; k < FRAME && (m_t % FRAME) != FRAME - 1; k++) tick();
        bus.value = 16'hBEEF;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        checks++;
        if (bus.digit_val !== 4'hF || bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load_edge got val=%h fs=%b want val=f fs=1",
                     bus.digit_val, bus.frame_start);
        end
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL wrap_load t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_multi_load();
        for (int k = 0; k < FRAME && (m_t % FRAME) != 2; k++) tick();
        bus.value = 16'h1111;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        repeat (3) tick();
        bus.value = 16'h2222;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (bus.digit_val === 4'h1 || obs !== exp_v) begin
                errors++;
                $display("FAIL multi_load t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.blank_lz = 1'b0;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 8; k++) tick();
        bus.value = 16'h7777;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        #2 rst_n  = 1'b0;
        model_reset();
        #1;
        obs = {bus.anodes, bus.digit_val, bus.digit_en, bus.frame_start};
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("FAIL reset_mid_async got=%b want=%b", obs, IDLE_OUT);
        end
        tick();
        #3 rst_n = 1'b1;
        repeat (FRAME + 4) begin
            tick();
            checks++;
            if (bus.digit_val !== 4'h0 || obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random t=%0d got=%b want=%b", m_t, obs, exp_v);
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();
        test_reset();
        test_load_midframe();
        test_blank();
        test_wrap_load();
        test_multi_load();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
